// File: rtl/duty_slew_pkg.sv
// Shared widths, FSM encoding and the saturation helper for the duty slew limiter.
package duty_slew_pkg;

  localparam int unsigned DUTY_W   = 14;
  localparam int          DUTY_MAX = 8191;

  typedef enum logic [1:0] {StIdle, StRamp, StHalt} state_e;

  // Clamp a signed duty to [-mag, +mag]; mag never exceeds DUTY_MAX so -8192 is unreachable.
  function automatic logic signed [DUTY_W-1:0] sat(input logic signed [DUTY_W-1:0] val,
                                                   input int                       mag);
    int v;
    v = int'(val);
    if (v > mag) begin
      return DUTY_W'(mag);
    end else if (v < -mag) begin
      return DUTY_W'(-mag);
    end
    return val;
  endfunction

endpackage

// File: rtl/duty_slew_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV cycles, never restarted by commands.
module tick_gen #(
  parameter int unsigned DIV = 8192
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     CntW   = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/duty_slew.sv
// Saturating slew-rate limiter feeding the H-bridge PWM: ramps duty toward the target once per tick.
module duty_slew
  import duty_slew_pkg::*;
#(
  parameter int unsigned TICK_DIV = 8192,
  parameter int unsigned STEP     = 64,
  parameter int unsigned MAX_MAG  = 8191
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DUTY_W-1:0] cmd,
  input  logic                     cmd_vld,
  input  logic                     halt,
  output logic signed [DUTY_W-1:0] duty,
  output logic                     wrt_duty,
  output logic                     at_target,
  output logic                     busy
);

  localparam int                     MagLim = (int'(MAX_MAG) > DUTY_MAX) ? DUTY_MAX : int'(MAX_MAG);
  localparam logic signed [DUTY_W:0] StepW  = (DUTY_W + 1)'(STEP);

  state_e                    state_q, state_d;
  logic signed [DUTY_W-1:0]  tgt_q, tgt_d;
  logic signed [DUTY_W-1:0]  duty_q, duty_d;
  logic                      wrt_q, wrt_d;
  logic                      tick;

  logic signed [DUTY_W:0]    diff, mag, stepped;
  logic signed [DUTY_W-1:0]  nxt;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // One slew step; a step that would cross or touch zero parks at zero for a tick.
  always_comb begin
    diff = {tgt_q[DUTY_W-1], tgt_q} - {duty_q[DUTY_W-1], duty_q};
    mag  = diff[DUTY_W] ? -diff : diff;
    if (mag <= StepW) begin
      stepped = {tgt_q[DUTY_W-1], tgt_q};
    end else if (diff[DUTY_W]) begin
      stepped = {duty_q[DUTY_W-1], duty_q} - StepW;
    end else begin
      stepped = {duty_q[DUTY_W-1], duty_q} + StepW;
    end
    nxt = stepped[DUTY_W-1:0];
    if ((duty_q != '0) && ((nxt == '0) || (nxt[DUTY_W-1] != duty_q[DUTY_W-1]))) begin
      nxt = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    wrt_d   = 1'b0;
    if (halt) begin
      state_d = StHalt;
      tgt_d   = '0;
      duty_d  = '0;
      wrt_d   = (duty_q != '0);
    end else begin
      // A command coincident with a tick is captured, but the step still aims at the old target.
      if (cmd_vld) begin
        tgt_d = sat(cmd, MagLim);
      end
      unique case (state_q)
        StIdle: begin
          if (tgt_q != duty_q) begin
            state_d = StRamp;
          end
        end
        StRamp: begin
          if (tick) begin
            duty_d = nxt;
            wrt_d  = (nxt != duty_q);
            if (nxt == tgt_q) begin
              state_d = StIdle;
            end
          end
        end
        StHalt:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      duty_q  <= '0;
      wrt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      wrt_q   <= wrt_d;
    end
  end

  assign duty      = duty_q;
  assign wrt_duty  = wrt_q;
  assign at_target = (duty_q == tgt_q);
  assign busy      = (state_q == StRamp);

endmodule

// File: tb/tb_duty_slew.sv
// Scoreboard bench for duty_slew: stimulus queues expected writes, a monitor checks each wrt_duty.
module tb_duty_slew;

  localparam int unsigned TickDiv = 16;

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic signed [13:0] cmd     = '0;
  logic               cmd_vld = 1'b0;
  logic               halt    = 1'b0;
  logic signed [13:0] duty;
  logic               wrt_duty;
  logic               at_target;
  logic               busy;

  typedef struct {
    int val;
    bit aligned;
    bit gap;
  } exp_t;

  exp_t exp_q[$];
  int   npass   = 0;
  int   nchk    = 0;
  int   ecnt    = 0;
  int   last_wr = 0;

  always #5 clk = ~clk;

  duty_slew #(
    .TICK_DIV (16),
    .STEP     (100),
    .MAX_MAG  (8000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .cmd_vld   (cmd_vld),
    .halt      (halt),
    .duty      (duty),
    .wrt_duty  (wrt_duty),
    .at_target (at_target),
    .busy      (busy)
  );

  // Edges since reset release; the prescaler count equals ecnt mod TickDiv.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input int got, input int want);
    nchk++;
    if (got == want) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wrt_duty) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write_count", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("duty_value", int'(duty), e.val);
        if (e.aligned) chk("tick_align", ecnt % TickDiv, 0);
        if (e.gap) chk("tick_gap", ecnt - last_wr, TickDiv);
      end
      last_wr = ecnt;
    end
  end

  task automatic push(input int v, input bit al, input bit gp);
    exp_t e;
    e.val     = v;
    e.aligned = al;
    e.gap     = gp;
    exp_q.push_back(e);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int c);
    cmd     = 14'(c);
    cmd_vld = 1'b1;
    step_clk();
    cmd_vld = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step_clk();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < TickDiv && (ecnt % TickDiv) != p; i++) step_clk();
  endtask

  // Expected write sequence for a long ramp with STEP=100, including the zero stop.
  task automatic push_ramp(input int from, input int to);
    int v;
    int d;
    int n;
    bit first;
    v     = from;
    first = 1'b1;
    while (v != to) begin
      d = to - v;
      if (d <= 100 && d >= -100) n = to;
      else n = (d > 0) ? v + 100 : v - 100;
      if (v != 0 && (n == 0 || ((n < 0) != (v < 0)))) n = 0;
      push(n, 1'b1, !first);
      first = 1'b0;
      v     = n;
    end
  endtask

  initial begin
    #12;
    chk("reset_duty", int'(duty), 0);
    chk("reset_wrt", int'(wrt_duty), 0);
    chk("reset_at_target", int'(at_target), 1);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_clk();

    // Positive ramp
    push(100, 1'b1, 1'b0);
    push(200, 1'b1, 1'b1);
    push(250, 1'b1, 1'b1);
    issue(250);
    step_clk();
    chk("pos_busy", int'(busy), 1);
    drain("pos_drain", 100);
    chk("pos_final", int'(duty), 250);
    chk("pos_at_target", int'(at_target), 1);
    chk("pos_idle", int'(busy), 0);

    // Saturation both ways
    push_ramp(250, 8000);
    issue(8191);
    drain("sat_pos_drain", 1500);
    chk("sat_pos_final", int'(duty), 8000);
    chk("sat_pos_at_target", int'(at_target), 1);
    push_ramp(8000, -8000);
    issue(-8192);
    drain("sat_neg_drain", 3000);
    chk("sat_neg_final", int'(duty), -8000);
    chk("sat_neg_at_target", int'(at_target), 1);

    // Asynchronous reset mid-ramp
    push(-7900, 1'b1, 1'b0);
    push(-7800, 1'b1, 1'b1);
    push(-7700, 1'b1, 1'b1);
    issue(150);
    drain("pre_reset_drain", 100);
    repeat (3) step_clk();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_duty", int'(duty), 0);
    chk("midreset_wrt", int'(wrt_duty), 0);
    chk("midreset_at_target", int'(at_target), 1);
    chk("midreset_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step_clk();

    // Reversal through a one-tick zero stop
    push(100, 1'b1, 1'b0);
    push(150, 1'b1, 1'b1);
    issue(150);
    drain("rev_setup_drain", 100);
    chk("rev_setup_final", int'(duty), 150);
    push(50, 1'b1, 1'b0);
    push(0, 1'b1, 1'b1);
    push(-100, 1'b1, 1'b1);
    push(-200, 1'b1, 1'b1);
    push(-250, 1'b1, 1'b1);
    issue(-250);
    drain("rev_drain", 200);
    chk("rev_final", int'(duty), -250);
    chk("rev_at_target", int'(at_target), 1);

    // Halt mid-ramp at -200
    push(-200, 1'b1, 1'b0);
    issue(-200);
    drain("halt_setup_drain", 100);
    issue(-600);
    step_clk();
    chk("halt_pre_busy", int'(busy), 1);
    push(0, 1'b0, 1'b0);
    halt = 1'b1;
    step_clk();
    chk("halt_duty", int'(duty), 0);
    chk("halt_wrt", int'(wrt_duty), 1);
    cmd     = 14'sd500;
    cmd_vld = 1'b1;
    step_clk();
    cmd_vld = 1'b0;
    repeat (20) step_clk();
    chk("halt_queue", exp_q.size(), 0);
    exp_q.delete();
    chk("halt_hold_duty", int'(duty), 0);
    halt = 1'b0;
    step_clk();
    step_clk();
    chk("halt_rel_busy", int'(busy), 0);
    chk("halt_rel_at_target", int'(at_target), 1);
    repeat (40) step_clk();
    chk("halt_rel_duty", int'(duty), 0);

    // cmd_vld coincident with the tick
    wait_phase(2);
    issue(100);
    push(100, 1'b1, 1'b0);
    push(200, 1'b1, 1'b1);
    push(300, 1'b1, 1'b1);
    wait_phase(15);
    chk("coin_busy", int'(busy), 1);
    cmd     = 14'sd300;
    cmd_vld = 1'b1;
    step_clk();
    cmd_vld = 1'b0;
    drain("coin_drain", 100);
    chk("coin_final", int'(duty), 300);
    chk("coin_at_target", int'(at_target), 1);
    chk("coin_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
